// File: rtl/sram_arbiter.sv
// sram_arbiter: arbitrates a capture-side write port and a USB-side read port
// onto one asynchronous 20-bit x 16-bit SRAM. Every access is followed by at
// least one IDLE cycle so the data bus can turn around.
// Optional macro SRAM_ARB_FAIRNESS_EN: starvation guard that hands a contested
// IDLE cycle to the read after STARVE_LIM consecutive write grants.
// Without it, writes have strict priority over reads.
module sram_arbiter #(
    parameter int unsigned STARVE_LIM = 8
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        WREQ,
    input  logic [19:0] WADR,
    input  logic [15:0] WDAT,
    output logic        WACK,
    input  logic        RREQ,
    input  logic [19:0] RADR,
    output logic        RACK,
    output logic [15:0] RDAT,
    output logic        RVALID,
    output logic [19:0] ADX,
    output logic [15:0] DXO,
    input  logic [15:0] DXI,
    output logic        DXOE,
    output logic        CEX,
    output logic        CEY,
    output logic        CE1,
    output logic        CE2,
    output logic        BHE,
    output logic        BLE,
    output logic        BUSY
);

    typedef enum logic [2:0] {IDLE, WSET, WPUL, WHLD, RSET, RSMP} state_t;

    if (STARVE_LIM < 1 || STARVE_LIM > 255) begin : g_lim_check
        $error("sram_arbiter: STARVE_LIM must be within 1..255");
    end

    state_t      state_q, state_d;
    logic [19:0] adx_q, adx_d;
    logic [15:0] dxo_q, dxo_d;
    logic [15:0] rdat_q, rdat_d;
    logic        wack_q, wack_d;
    logic        rack_q, rack_d;
    logic        dxoe_q, dxoe_d;
    logic        cex_q, cex_d;
    logic        cey_q, cey_d;
    logic        ce1_q, ce1_d;
    logic        ce2_q, ce2_d;
    logic        ben_q, ben_d;
    logic        busy_q, busy_d;
    logic        ce_on;
    logic        grant_w, grant_r;

`ifdef SRAM_ARB_FAIRNESS_EN
    localparam logic [7:0] LIM = 8'(STARVE_LIM);

    logic [7:0] starve_q, starve_d;

    // Grant decision in IDLE with the starvation counter deciding contested cycles.
    always_comb begin
        grant_w  = 1'b0;
        grant_r  = 1'b0;
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (RREQ && (!WREQ || starve_q == LIM)) begin
                grant_r  = 1'b1;
                starve_d = '0;
            end else if (WREQ) begin
                grant_w  = 1'b1;
                starve_d = RREQ ? starve_q + 8'd1 : '0;
            end else begin
                starve_d = '0;
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // Grant decision in IDLE: writes always win a contested cycle.
    always_comb begin
        grant_w = (state_q == IDLE) && WREQ;
        grant_r = (state_q == IDLE) && RREQ && !WREQ;
    end
`endif

    // Next state, access registers, and SRAM strobes decoded from the next state.
    always_comb begin
        state_d = state_q;
        adx_d   = adx_q;
        dxo_d   = dxo_q;
        rdat_d  = rdat_q;
        case (state_q)
            IDLE: begin
                if (grant_w) begin
                    state_d = WSET;
                    adx_d   = WADR;
                    dxo_d   = WDAT;
                end else if (grant_r) begin
                    state_d = RSET;
                    adx_d   = RADR;
                end
            end
            WSET:    state_d = WPUL;
            WPUL:    state_d = WHLD;
            WHLD:    state_d = IDLE;
            RSET:    state_d = RSMP;
            RSMP: begin
                state_d = IDLE;
                rdat_d  = DXI;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        ce_on  = (state_d != IDLE);
        ce1_d  = !ce_on;
        ce2_d  = ce_on;
        ben_d  = !ce_on;
        busy_d = ce_on;
        dxoe_d = (state_d == WSET) || (state_d == WPUL) || (state_d == WHLD);
        cey_d  = (state_d != WPUL);
        cex_d  = !((state_d == RSET) || (state_d == RSMP));
        wack_d = (state_d == WHLD);
        rack_d = (state_q == RSMP);
    end

    // FSM state and registered outputs; reset releases every strobe at once.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            adx_q   <= '0;
            dxo_q   <= '0;
            rdat_q  <= '0;
            wack_q  <= 1'b0;
            rack_q  <= 1'b0;
            dxoe_q  <= 1'b0;
            cex_q   <= 1'b1;
            cey_q   <= 1'b1;
            ce1_q   <= 1'b1;
            ce2_q   <= 1'b0;
            ben_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adx_q   <= adx_d;
            dxo_q   <= dxo_d;
            rdat_q  <= rdat_d;
            wack_q  <= wack_d;
            rack_q  <= rack_d;
            dxoe_q  <= dxoe_d;
            cex_q   <= cex_d;
            cey_q   <= cey_d;
            ce1_q   <= ce1_d;
            ce2_q   <= ce2_d;
            ben_q   <= ben_d;
            busy_q  <= busy_d;
        end
    end

    assign ADX    = adx_q;
    assign DXO    = dxo_q;
    assign RDAT   = rdat_q;
    assign WACK   = wack_q;
    assign RACK   = rack_q;
    assign RVALID = rack_q;
    assign DXOE   = dxoe_q;
    assign CEX    = cex_q;
    assign CEY    = cey_q;
    assign CE1    = ce1_q;
    assign CE2    = ce2_q;
    assign BHE    = ben_q;
    assign BLE    = ben_q;
    assign BUSY   = busy_q;

endmodule
